if_id_stage: RTL

Instruction-fetch front end of the 5-stage pipeline: owns the program counter and the IF/ID pipeline register. It consumes the PC-stall and IF/ID-stall requests from the load-use hazard unit and the taken-branch redirect from MEM. It presents the PC to instruction memory and delivers the fetched instruction, PC+4 and a valid bit to ID. Saturating stall/flush counters support performance debug.

---
 rtl/if_id_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// Instruction-fetch front end: program counter, IF/ID pipeline register and
// saturating stall/flush debug counters for the 5-stage pipeline.
module if_id_stage #(
   parameter int unsigned          PC_WIDTH    = 32,
   parameter int unsigned          INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
   parameter int unsigned          CNT_WIDTH   = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   pc_stall_i,
   input  logic                   if_id_stall_i,
   input  logic                   branch_taken_i,
   input  logic [PC_WIDTH-1:0]    branch_target_i,
   input  logic [INSTR_WIDTH-1:0] imem_instr_i,
   output logic [PC_WIDTH-1:0]    imem_addr_o,
   output logic [INSTR_WIDTH-1:0] if_id_instr_o,
   output logic [PC_WIDTH-1:0]    if_id_pc4_o,
   output logic                   if_id_valid_o,
   output logic [CNT_WIDTH-1:0]   stall_cnt_o,
   output logic [CNT_WIDTH-1:0]   flush_cnt_o,
   output logic                   stall_mismatch_o
);

   localparam logic [PC_WIDTH-1:0]  PC_STEP = PC_WIDTH'(4);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [PC_WIDTH-1:0]    pc_q,        pc_d;
   logic [INSTR_WIDTH-1:0] instr_q,     instr_d;
   logic [PC_WIDTH-1:0]    pc4_q,       pc4_d;
   logic                   valid_q,     valid_d;
   logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;
   logic                   mismatch_q,  mismatch_d;
   logic [PC_WIDTH-1:0]    pc_plus4;

   // Per-cycle priority: redirect beats stall beats sequential fetch.
   always_comb begin
      pc_plus4    = pc_q + PC_STEP;
      pc_d        = pc_q;
      instr_d     = instr_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      mismatch_d  = mismatch_q;

      if (branch_taken_i) begin
         pc_d = branch_target_i;
      end else if (!pc_stall_i) begin
         pc_d = pc_plus4;
      end

      if (branch_taken_i) begin
         instr_d = '0;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (!if_id_stall_i) begin
         instr_d = imem_instr_i;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
      end

      if (branch_taken_i) begin
         if (flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
         end
      end else if (pc_stall_i && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end

      // Sticky flag: hazard unit disagreed with itself outside a flush.
      if ((pc_stall_i != if_id_stall_i) && !branch_taken_i) begin
         mismatch_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q        <= RESET_PC;
         instr_q     <= '0;
         pc4_q       <= '0;
         valid_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         mismatch_q  <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         pc4_q       <= pc4_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         mismatch_q  <= mismatch_d;
      end
   end

   assign imem_addr_o      = pc_q;
   assign if_id_instr_o    = instr_q;
   assign if_id_pc4_o      = pc4_q;
   assign if_id_valid_o    = valid_q;
   assign stall_cnt_o      = stall_cnt_q;
   assign flush_cnt_o      = flush_cnt_q;
   assign stall_mismatch_o = mismatch_q;

endmodule
